regfile_param: RTL and testbench

Parametrised successor to the CPU register file. It provides one write port and two asynchronous read ports over a 2^ADDR_WIDTH × DATA_WIDTH array, with:
- an optional hardwired-zero register 0;
- optional write-to-read bypass;
- a per-register pending-write scoreboard for the pipeline hazard unit;
- a sequenced bulk-clear operation.

It sits between decode (reads, claims) and writeback (writes).

---
 rtl/regfile_param.sv | 133 +++++++++++++
 tb/tb_regfile_param.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// regfile_param: 2^ADDR_WIDTH x DATA_WIDTH register file with one write port,
// two combinational read ports, optional hardwired zero register, optional
// write-to-read bypass, a pending-write scoreboard and a sequenced bulk clear.
module regfile_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clock,
  input  logic                  ctrl_reset_n,
  input  logic                  ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB,
  input  logic                  ctrl_claimEnable,
  input  logic [ADDR_WIDTH-1:0] ctrl_claimReg,
  output logic                  busy_readRegA,
  output logic                  busy_readRegB,
  input  logic                  ctrl_clear,
  output logic                  clear_busy
);
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam bit LP_ZR  = (ZERO_REG != 0);
  localparam bit LP_BYP = (BYPASS != 0);
  localparam int NPORTS = 2;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                           r_state;
  logic [ADDR_WIDTH-1:0]            r_idx;
  logic                             r_clear_busy;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] r_mem;
  logic [DEPTH-1:0]                 r_busy;

  logic w_idle, w_wr_en, w_claim_en;

  // Writes and claims only land in IDLE; the zero register swallows both.
  assign w_idle     = (r_state == S_IDLE);
  assign w_wr_en    = w_idle && ctrl_writeEnable && !(LP_ZR && (ctrl_writeReg == '0));
  assign w_claim_en = w_idle && ctrl_claimEnable && !(LP_ZR && (ctrl_claimReg == '0));
  assign clear_busy = r_clear_busy;

  // Bulk-clear sequencer: one register zeroed per cycle, index wraps back to IDLE.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_clear_busy <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ctrl_clear) begin
            r_state      <= S_CLEAR;
            r_idx        <= '0;
            r_clear_busy <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_idx <= r_idx + 1'b1;
          if (&r_idx) begin
            r_state      <= S_IDLE;
            r_clear_busy <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_clear_busy <= 1'b0;
        end
      endcase
    end
  end

  // Array update: sweep zeroing in CLEAR, normal writes in IDLE (including the
  // cycle ctrl_clear is seen; the sweep later zeroes that register anyway).
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_mem <= '0;
    end else if (r_state == S_CLEAR) begin
      r_mem[r_idx] <= '0;
    end else if (w_wr_en) begin
      r_mem[ctrl_writeReg] <= data_writeReg;
    end
  end

  // Pending-write scoreboard; claim is applied last so it wins over a same-cycle write.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_busy <= '0;
    end else if (w_idle && ctrl_clear) begin
      r_busy <= '0;
    end else if (w_idle) begin
      if (w_wr_en)    r_busy[ctrl_writeReg] <= 1'b0;
      if (w_claim_en) r_busy[ctrl_claimReg] <= 1'b1;
    end
  end

  logic [NPORTS-1:0][ADDR_WIDTH-1:0] w_raddr;
  logic [NPORTS-1:0][DATA_WIDTH-1:0] w_rdata;
  logic [NPORTS-1:0]                 w_rbusy;

  assign w_raddr = {ctrl_readRegB, ctrl_readRegA};

  for (genvar p = 0; p < NPORTS; p++) begin : g_rd
    logic w_zero, w_hit, w_claim_hit;
    assign w_zero      = LP_ZR && (w_raddr[p] == '0);
    // Bypass never fires in reset or during the sweep, nor for the zero register.
    assign w_hit       = LP_BYP && ctrl_reset_n && w_idle && ctrl_writeEnable &&
                         (ctrl_writeReg == w_raddr[p]) && !w_zero;
    assign w_claim_hit = ctrl_claimEnable && (ctrl_claimReg == w_raddr[p]);
    // Read mux: zero register, then forwarded write data, then array contents.
    always_comb begin
      w_rdata[p] = r_mem[w_raddr[p]];
      w_rbusy[p] = r_busy[w_raddr[p]];
      if (w_zero) begin
        w_rdata[p] = '0;
        w_rbusy[p] = 1'b0;
      end else if (w_hit) begin
        w_rdata[p] = data_writeReg;
        if (!w_claim_hit) w_rbusy[p] = 1'b0;
      end
    end
  end

  assign data_readRegA = w_rdata[0];
  assign data_readRegB = w_rdata[1];
  assign busy_readRegA = w_rbusy[0];
  assign busy_readRegB = w_rbusy[1];

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;
  logic        clock = 1'b0;
  logic        rst_n;
  logic        we, claim, clr;
  logic [4:0]  wa, ra, rb, cr;
  logic [31:0] wd;
  logic [31:0] rdA, rdB, nb_rdA, nb_rdB;
  logic        bA, bB, cb, nb_bA, nb_bB, nb_cb;

  always #5 clock = ~clock;

  regfile_param dut (
    .clock(clock), .ctrl_reset_n(rst_n),
    .ctrl_writeEnable(we), .ctrl_writeReg(wa), .data_writeReg(wd),
    .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(rdA), .data_readRegB(rdB),
    .ctrl_claimEnable(claim), .ctrl_claimReg(cr),
    .busy_readRegA(bA), .busy_readRegB(bB),
    .ctrl_clear(clr), .clear_busy(cb)
  );

  regfile_param #(.BYPASS(0)) dut_nb (
    .clock(clock), .ctrl_reset_n(rst_n),
    .ctrl_writeEnable(we), .ctrl_writeReg(wa), .data_writeReg(wd),
    .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(nb_rdA), .data_readRegB(nb_rdB),
    .ctrl_claimEnable(claim), .ctrl_claimReg(cr),
    .busy_readRegA(nb_bA), .busy_readRegB(nb_bB),
    .ctrl_clear(clr), .clear_busy(nb_cb)
  );

  typedef enum int {RDA, RDB, BSA, BSB, CLB, NB_RDA, NB_BSB} sel_t;
  typedef struct {
    int          cyc;
    sel_t        sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cycnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clock) cycnt <= cycnt + 1;

  task automatic expect_v(input sel_t sel, input logic [31:0] exp, input string name);
    sb.push_back('{cyc: cycnt, sel: sel, exp: exp, name: name});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cycnt) begin
      e = sb.pop_front();
      case (e.sel)
        RDA:     act = rdA;
        RDB:     act = rdB;
        BSA:     act = {31'b0, bA};
        BSB:     act = {31'b0, bB};
        CLB:     act = {31'b0, cb};
        NB_RDA:  act = nb_rdA;
        default: act = {31'b0, nb_bB};
      endcase
      n_tests++;
      if (e.cyc != cycnt || act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h (cycle %0d due %0d)", e.name, act, e.exp, cycnt, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; we = 0; claim = 0; clr = 0;
    wa = 0; ra = 0; rb = 0; cr = 0; wd = 0;
    tick();
    we = 1; wa = 7; wd = 32'h55; ra = 7; rb = 3;
    expect_v(RDA, 32'h0, "reset_rdA_nobypass");
    expect_v(BSB, 32'h0, "reset_busyB");
    expect_v(CLB, 32'h0, "reset_clear_busy");
    #1;
    n_tests++;
    if (rdA !== 32'h0 || cb !== 1'b0) begin
      n_fail++;
      $display("FAIL direct_reset: rdA %h cb %b", rdA, cb);
    end
    tick();
    we = 0; rst_n = 1'b1;
    expect_v(RDA, 32'h0, "post_reset_r7");
    tick();

    we = 1; wa = 5; wd = 32'hDEADBEEF;
    tick();
    we = 0; ra = 5; rb = 5;
    expect_v(RDA, 32'hDEADBEEF, "wr_r5_rdA");
    expect_v(RDB, 32'hDEADBEEF, "wr_r5_rdB");
    tick();
    rb = 6;
    expect_v(RDB, 32'h0, "unwritten_r6");
    tick();

    we = 1; wa = 0; wd = 32'h1234; claim = 1; cr = 0; ra = 0;
    expect_v(RDA, 32'h0, "r0_same_cycle");
    tick();
    we = 0; claim = 0;
    expect_v(RDA, 32'h0, "r0_after_write");
    expect_v(BSA, 32'h0, "r0_not_busy");
    tick();

    ra = 7; we = 1; wa = 7; wd = 32'hA5A5A5A5;
    expect_v(RDA, 32'hA5A5A5A5, "bypass_same_cycle");
    expect_v(NB_RDA, 32'h0, "nobypass_old_value");
    #1;
    n_tests++;
    if (rdA !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL direct_bypass: got %h", rdA);
    end
    tick();
    we = 0;
    expect_v(RDA, 32'hA5A5A5A5, "bypass_next_cycle");
    expect_v(NB_RDA, 32'hA5A5A5A5, "nobypass_next_cycle");
    tick();

    rb = 3; claim = 1; cr = 3;
    expect_v(BSB, 32'h0, "claim_r3_not_yet");
    tick();
    claim = 0;
    expect_v(BSB, 32'h1, "claim_r3_busy");
    tick();
    we = 1; wa = 3; wd = 32'h33;
    expect_v(BSB, 32'h0, "write_r3_masked");
    expect_v(NB_BSB, 32'h1, "write_r3_nobypass_busy");
    tick();
    we = 0;
    expect_v(BSB, 32'h0, "write_r3_cleared");
    expect_v(NB_BSB, 32'h0, "write_r3_nb_cleared");
    tick();
    claim = 1; cr = 3; we = 1; wa = 3; wd = 32'h44;
    expect_v(BSB, 32'h0, "claim_write_same_cycle");
    tick();
    claim = 0; we = 0;
    expect_v(BSB, 32'h1, "claim_wins");
    expect_v(RDB, 32'h44, "claim_write_data");
    tick();

    for (int i = 1; i < 32; i++) begin
      we = 1; wa = i[4:0]; wd = 32'h1000_0000 + i;
      tick();
    end
    we = 0; claim = 1; cr = 3; ra = 31; rb = 3;
    expect_v(RDA, 32'h1000_001F, "preload_r31");
    tick();
    claim = 0;
    expect_v(BSB, 32'h1, "preclear_busy_r3");
    clr = 1; we = 1; wa = 9; wd = 32'h99; ra = 9;
    expect_v(CLB, 32'h0, "clear_not_yet");
    tick();
    clr = 0; we = 0;
    for (int k = 0; k < 32; k++) begin
      if (k == 3) clr = 1;
      if (k == 5) begin we = 1; wa = 9; wd = 32'hBAD; end
      if (k == 6) begin claim = 1; cr = 20; end
      expect_v(CLB, 32'h1, $sformatf("clear_busy_k%0d", k));
      expect_v(BSB, 32'h0, $sformatf("clear_busy_r3_k%0d", k));
      expect_v(RDA, (k <= 9) ? 32'h99 : 32'h0, $sformatf("sweep_r9_k%0d", k));
      tick();
      clr = 0; we = 0; claim = 0;
    end
    we = 1; wa = 2; wd = 32'h22; ra = 2;
    expect_v(CLB, 32'h0, "clear_done");
    expect_v(RDA, 32'h22, "post_clear_bypass");
    tick();
    we = 0;
    for (int i = 0; i < 32; i++) begin
      ra = i[4:0]; rb = i[4:0];
      expect_v(RDA, (i == 2) ? 32'h22 : 32'h0, $sformatf("post_clear_r%0d", i));
      expect_v(BSB, 32'h0, $sformatf("post_clear_busy_r%0d", i));
      expect_v(CLB, 32'h0, $sformatf("idle_cb_%0d", i));
      tick();
    end

    we = 1; wa = 20; wd = 32'h2020;
    tick();
    we = 0; claim = 1; cr = 5;
    tick();
    claim = 0; clr = 1;
    tick();
    clr = 0; ra = 20; rb = 5;
    for (int k = 0; k < 10; k++) tick();
    rst_n = 1'b0;
    expect_v(CLB, 32'h0, "midclear_reset_cb");
    expect_v(RDA, 32'h0, "midclear_reset_r20");
    expect_v(BSB, 32'h0, "midclear_reset_busy");
    #1;
    n_tests++;
    if (cb !== 1'b0 || rdA !== 32'h0) begin
      n_fail++;
      $display("FAIL direct_midclear_reset: cb %b rdA %h", cb, rdA);
    end
    tick();
    rst_n = 1'b1;
    we = 1; wa = 2; wd = 32'h77; ra = 2;
    tick();
    we = 0;
    expect_v(RDA, 32'h77, "after_reset_write_r2");
    expect_v(CLB, 32'h0, "after_reset_idle");
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_v(CLB, 32'h0, $sformatf("no_resume_%0d", k));
    end
    tick();
    tick();
    while (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unchecked_%s: got none expected %h", sb[0].name, sb[0].exp);
      void'(sb.pop_front());
    end
    if (n_fail != 0) $display("FAIL summary: %0d failures", n_fail);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
